hsynth_capture_dma_sched: RTL and testbench

//  Schedules SoCFPGA DMA peripheral requests for the synth capture FIFO (64b->32b, APB read side).

---
 rtl/hsynth_capture_dma_sched.sv | 177 +++++++++++++++++
 tb/tb_hsynth_capture_dma_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsynth_capture_dma_sched.sv
// DMA request scheduler for the synth capture FIFO read side: picks burst or single
// requests from the fill level, tracks APB pops, and flags overruns and drain timeouts.
module hsynth_capture_dma_sched #(
    parameter int unsigned USEDW_W   = 4,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic [USEDW_W-1:0] fifo_used,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic               fifo_read,
    input  logic               capture_write,
    input  logic               dma_ack,
    input  logic               irq_clear,
    output logic               dma_req,
    output logic               dma_single,
    output logic               overrun,
    output logic               timeout_err,
    output logic [7:0]         overrun_cnt,
    output logic [15:0]        words_xfer,
    output logic [1:0]         state
);

    localparam int unsigned RemW   = $clog2(BURST_LEN + 1);
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSingle = 2'd1;
    localparam logic [1:0] StBurst  = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    localparam logic [RemW-1:0]    BurstRemain = RemW'(BURST_LEN);
    localparam logic [TimerW-1:0]  TimerLast   = TimerW'(TIMEOUT - 1);
    localparam logic [USEDW_W:0]   BurstLevel  = (USEDW_W + 1)'(BURST_LEN);

    logic [1:0]        state_q, state_d;
    logic [RemW-1:0]   remain_q, remain_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              req_q, req_d;
    logic              single_q, single_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;
    logic [15:0]       words_q, words_d;

    logic              pop;
    logic              ovr_set;
    logic              to_set;
    logic              burst_ready;
    logic [RemW-1:0]   remain_dec;

    assign pop         = fifo_read & ~fifo_empty;
    assign ovr_set     = capture_write & fifo_full;
    assign burst_ready = {1'b0, fifo_used} >= BurstLevel;
    // Pops beyond the outstanding count only bump words_xfer.
    assign remain_dec  = (pop && remain_q != '0) ? remain_q - RemW'(1) : remain_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        timer_d  = timer_q;
        to_set   = 1'b0;
        if (flush) begin
            state_d  = StIdle;
            remain_d = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    timer_d = '0;
                    if (enable) begin
                        if (burst_ready) begin
                            state_d  = StBurst;
                            remain_d = BurstRemain;
                        end else if (!fifo_empty) begin
                            state_d  = StSingle;
                            remain_d = RemW'(1);
                        end
                    end
                end
                StSingle, StBurst: begin
                    if (dma_ack) begin
                        state_d = StDrain;
                        timer_d = '0;
                    end
                end
                StDrain: begin
                    // A final pop on the timeout cycle completes normally.
                    if (remain_dec == '0) begin
                        state_d  = StIdle;
                        remain_d = '0;
                        timer_d  = '0;
                    end else if (timer_q == TimerLast) begin
                        state_d  = StIdle;
                        remain_d = '0;
                        timer_d  = '0;
                        to_set   = 1'b1;
                    end else begin
                        remain_d = remain_dec;
                        timer_d  = timer_q + TimerW'(1);
                    end
                end
                default: begin
                    state_d  = StIdle;
                    remain_d = '0;
                    timer_d  = '0;
                end
            endcase
        end
    end

    assign req_d    = (state_d == StBurst);
    assign single_d = (state_d == StSingle);

    always_comb begin
        words_d = flush ? 16'd0 : words_q + 16'(pop);

        overrun_d = overrun_q;
        ovr_cnt_d = ovr_cnt_q;
        // Set beats clear when both land on the same cycle.
        if (ovr_set) begin
            overrun_d = 1'b1;
            if (irq_clear) begin
                ovr_cnt_d = 8'd1;
            end else if (ovr_cnt_q != 8'hff) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end else if (irq_clear) begin
            overrun_d = 1'b0;
            ovr_cnt_d = 8'd0;
        end

        timeout_d = timeout_q;
        if (to_set) begin
            timeout_d = 1'b1;
        end else if (irq_clear) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            remain_q  <= '0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            single_q  <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            ovr_cnt_q <= 8'd0;
            words_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            single_q  <= single_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            ovr_cnt_q <= ovr_cnt_d;
            words_q   <= words_d;
        end
    end

    assign state       = state_q;
    assign dma_req     = req_q;
    assign dma_single  = single_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign overrun_cnt = ovr_cnt_q;
    assign words_xfer  = words_q;

endmodule

// File: tb/tb_hsynth_capture_dma_sched.sv
// Bench for hsynth_capture_dma_sched: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_hsynth_capture_dma_sched;

    localparam int USEDW_W   = 4;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT   = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, flush, fifo_empty, fifo_full, fifo_read;
    logic        capture_write, dma_ack, irq_clear;
    logic [3:0]  fifo_used;
    logic        dma_req, dma_single, overrun, timeout_err;
    logic [7:0]  overrun_cnt;
    logic [15:0] words_xfer;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    // Model: state as 0 idle, 1 single, 2 burst, 3 drain.
    int m_state, m_rem, m_tmr, m_cnt, m_words;
    bit m_ovr, m_to;

    always #5 clk = ~clk;

    hsynth_capture_dma_sched #(
        .USEDW_W  (USEDW_W),
        .BURST_LEN(BURST_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .fifo_used    (fifo_used),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_read    (fifo_read),
        .capture_write(capture_write),
        .dma_ack      (dma_ack),
        .irq_clear    (irq_clear),
        .dma_req      (dma_req),
        .dma_single   (dma_single),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .overrun_cnt  (overrun_cnt),
        .words_xfer   (words_xfer),
        .state        (state)
    );

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_tmr = 0; m_cnt = 0; m_words = 0;
        m_ovr = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit popped, ovr_hit, to_hit;
        int left;
        popped  = fifo_read && !fifo_empty;
        ovr_hit = capture_write && fifo_full;
        to_hit  = 0;
        if (flush) begin
            m_state = 0; m_rem = 0; m_tmr = 0; m_words = 0;
        end else begin
            if (popped) m_words = (m_words + 1) % 65536;
            if (m_state == 0) begin
                m_tmr = 0;
                if (enable && int'(fifo_used) >= BURST_LEN) begin
                    m_state = 2; m_rem = BURST_LEN;
                end else if (enable && !fifo_empty) begin
                    m_state = 1; m_rem = 1;
                end
            end else if (m_state == 1 || m_state == 2) begin
                if (dma_ack) begin
                    m_state = 3; m_tmr = 0;
                end
            end else begin
                left = (popped && m_rem > 0) ? m_rem - 1 : m_rem;
                m_tmr = m_tmr + 1;
                if (left == 0) begin
                    m_state = 0; m_rem = 0; m_tmr = 0;
                end else if (m_tmr >= TIMEOUT) begin
                    m_state = 0; m_rem = 0; m_tmr = 0; to_hit = 1;
                end else begin
                    m_rem = left;
                end
            end
        end
        if (ovr_hit) begin
            m_ovr = 1;
            m_cnt = irq_clear ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        end else if (irq_clear) begin
            m_ovr = 0; m_cnt = 0;
        end
        if (to_hit) m_to = 1;
        else if (irq_clear) m_to = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 0; flush = 0; fifo_used = 0; fifo_empty = 1; fifo_full = 0;
        fifo_read = 0; capture_write = 0; dma_ack = 0; irq_clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dma_req, dma_single, overrun, timeout_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {dma_req, dma_single, overrun, timeout_err});
        end
        checks++;
        if (state !== 2'd0 || overrun_cnt !== 8'd0 || words_xfer !== 16'd0) begin
            failures++;
            $display("FAIL reset_values got state=%0d cnt=%0d words=%0d exp 0/0/0",
                     state, overrun_cnt, words_xfer);
        end
        reset = 0;
        step();
    endtask

    task automatic test_burst();
        enable = 1; fifo_used = 8; fifo_empty = 0;
        step();
        checks++;
        if (dma_req !== 1'b1 || dma_single !== 1'b0 || state !== 2'd2) begin
            failures++;
            $display("FAIL burst_req got req=%b single=%b state=%0d exp 1/0/2", dma_req, dma_single, state);
        end
        dma_ack = 1;
        step();
        dma_ack = 0;
        checks++;
        if (dma_req !== 1'b0 || state !== 2'd3) begin
            failures++;
            $display("FAIL burst_ack got req=%b state=%0d exp 0/3", dma_req, state);
        end
        fifo_read = 1;
        repeat (7) step();
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL burst_drain7 got state=%0d exp 3", state);
        end
        enable = 0;
        step();
        fifo_read = 0;
        checks++;
        if (state !== 2'd0 || words_xfer !== 16'd8 || words_xfer !== 16'(m_words)) begin
            failures++;
            $display("FAIL burst_done got state=%0d words=%0d exp 0/8", state, words_xfer);
        end
    endtask

    task automatic test_single();
        enable = 1; fifo_used = 3; fifo_empty = 0;
        step();
        checks++;
        if (dma_single !== 1'b1 || dma_req !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL single_req got single=%b req=%b state=%0d exp 1/0/1", dma_single, dma_req, state);
        end
        dma_ack = 1;
        step();
        dma_ack = 0;
        fifo_read = 1;
        step();
        fifo_read = 0;
        fifo_used = 2;
        checks++;
        if (state !== 2'd0 || dma_single !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got state=%0d single=%b exp 0/0", state, dma_single);
        end
        step();
        checks++;
        if (dma_single !== 1'b1 || state !== 2'd1) begin
            failures++;
            $display("FAIL single_again got single=%b state=%0d exp 1/1", dma_single, state);
        end
        enable = 0; dma_ack = 1;
        step();
        dma_ack = 0; fifo_read = 1;
        step();
        fifo_read = 0;
    endtask

    task automatic test_enable_drop();
        enable = 1; fifo_used = 10; fifo_empty = 0;
        step();
        enable = 0;
        repeat (3) step();
        checks++;
        if (dma_req !== 1'b1 || state !== 2'd2) begin
            failures++;
            $display("FAIL en_drop_hold got req=%b state=%0d exp 1/2", dma_req, state);
        end
        dma_ack = 1;
        step();
        dma_ack = 0; fifo_read = 1;
        repeat (8) step();
        fifo_read = 0;
        repeat (3) step();
        checks++;
        if (state !== 2'd0 || dma_req !== 1'b0 || dma_single !== 1'b0 || state !== 2'(m_state)) begin
            failures++;
            $display("FAIL en_drop_idle got state=%0d req=%b single=%b exp 0/0/0", state, dma_req, dma_single);
        end
    endtask

    task automatic test_flush();
        fifo_full = 1; capture_write = 1;
        step();
        fifo_full = 0; capture_write = 0;
        enable = 1; fifo_used = 12; fifo_empty = 0;
        step();
        checks++;
        if (dma_req !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre got req=%b exp 1", dma_req);
        end
        flush = 1; fifo_read = 1; dma_ack = 1;
        step();
        flush = 0; fifo_read = 0; dma_ack = 0; enable = 0;
        checks++;
        if (dma_req !== 1'b0 || state !== 2'd0 || words_xfer !== 16'd0) begin
            failures++;
            $display("FAIL flush_clear got req=%b state=%0d words=%0d exp 0/0/0", dma_req, state, words_xfer);
        end
        checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL flush_sticky got ovr=%b cnt=%0d exp 1/%0d", overrun, overrun_cnt, m_cnt);
        end
    endtask

    task automatic test_overrun();
        irq_clear = 1;
        step();
        irq_clear = 0; fifo_full = 1; capture_write = 1;
        repeat (300) step();
        checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL ovr_sat got ovr=%b cnt=%0d exp 1/255", overrun, overrun_cnt);
        end
        irq_clear = 1;
        step();
        checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL ovr_setclr got ovr=%b cnt=%0d exp 1/1", overrun, overrun_cnt);
        end
        fifo_full = 0; capture_write = 0;
        step();
        irq_clear = 0;
        checks++;
        if (overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL ovr_clear got ovr=%b cnt=%0d exp 0/0", overrun, overrun_cnt);
        end
    endtask

    task automatic test_timeout();
        enable = 1; fifo_used = 8; fifo_empty = 0;
        step();
        enable = 0; dma_ack = 1;
        step();
        dma_ack = 0;
        repeat (TIMEOUT - 1) step();
        checks++;
        if (state !== 2'd3 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_early got state=%0d to=%b exp 3/0", state, timeout_err);
        end
        step();
        checks++;
        if (state !== 2'd0 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_fire got state=%0d to=%b exp 0/1", state, timeout_err);
        end
        irq_clear = 1;
        step();
        irq_clear = 0;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_clear got to=%b exp 0", timeout_err);
        end
    endtask

    task automatic test_async_reset();
        enable = 1; fifo_used = 9; fifo_empty = 0;
        step();
        #2;
        reset = 1;
        #1;
        checks++;
        if (dma_req !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL async_reset got req=%b state=%0d exp 0/0", dma_req, state);
        end
        idle_inputs();
        model_reset();
        @(posedge clk);
        #3;
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            enable        = ($urandom_range(0, 9) < 8);
            flush         = ($urandom_range(0, 99) < 2);
            fifo_used     = 4'($urandom_range(0, 15));
            fifo_empty    = (fifo_used == 0) || ($urandom_range(0, 9) == 0);
            fifo_full     = ($urandom_range(0, 9) < 2);
            capture_write = $urandom_range(0, 1);
            fifo_read     = ($urandom_range(0, 9) < 3);
            dma_ack       = ($urandom_range(0, 9) < 3);
            irq_clear     = ($urandom_range(0, 49) == 0);
            step();
            checks++;
            if (state !== 2'(m_state) || dma_req !== (m_state == 2) || dma_single !== (m_state == 1)) begin
                failures++;
                $display("FAIL rand_fsm cyc=%0d got state=%0d req=%b single=%b exp state=%0d",
                         i, state, dma_req, dma_single, m_state);
            end
            checks++;
            if (overrun !== m_ovr || overrun_cnt !== 8'(m_cnt) || timeout_err !== m_to) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d got ovr=%b cnt=%0d to=%b exp %b/%0d/%b",
                         i, overrun, overrun_cnt, timeout_err, m_ovr, m_cnt, m_to);
            end
            checks++;
            if (words_xfer !== 16'(m_words)) begin
                failures++;
                $display("FAIL rand_words cyc=%0d got=%0d exp=%0d", i, words_xfer, m_words);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_enable_drop();
        test_flush();
        test_overrun();
        test_timeout();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
